// File: rtl/dmux_stream.sv
// Valid/ready stream demultiplexer: routes each input beat to one of N single-entry output registers.
// Optional out-of-range error reporting is compiled in with `define DMUX_ERR_EN.
module dmux_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [N*WIDTH-1:0] out_data
`ifdef DMUX_ERR_EN
    ,
    output logic              err,
    output logic [7:0]        err_cnt
`endif
);

    logic [N-1:0]       r_valid;
    logic [N*WIDTH-1:0] r_data;
    logic [N-1:0]       w_hit;
    logic [N-1:0]       w_load;
    logic               w_sel_ready;
    logic               w_accept;

    // Out-of-range selects hit no channel, so w_sel_ready stays 1 and the beat is dropped.
    always_comb begin
        w_hit       = '0;
        w_sel_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (32'(in_sel) == k) begin
                w_hit[k]    = 1'b1;
                w_sel_ready = !r_valid[k] || out_ready[k];
            end
        end
    end

    assign in_ready  = !reset && w_sel_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_load    = w_hit & {N{w_accept}};
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) begin
                    r_valid[k]                 <= 1'b1;
                    r_data[k*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DMUX_ERR_EN
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_drop;

    assign w_drop  = w_accept && !(|w_hit);
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_drop;
            if (w_drop && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Directed self-checking bench for dmux_stream: an N=4 instance and an N=3 instance
// (the latter exercises out-of-range selects).
module tb_dmux_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [1:0]  in_sel4 = '0;
    logic [15:0] in_data4 = '0;
    logic [3:0]  out_valid4;
    logic [3:0]  out_ready4 = 4'hF;
    logic [63:0] out_data4;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [1:0]  in_sel3 = '0;
    logic [15:0] in_data3 = '0;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3 = 3'h7;
    logic [47:0] out_data3;

`ifdef DMUX_ERR_EN
    logic        err4, err3;
    logic [7:0]  err_cnt4, err_cnt3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmux_stream #(.WIDTH(16), .N(4), .SELW(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_sel    (in_sel4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
`ifdef DMUX_ERR_EN
        ,
        .err       (err4),
        .err_cnt   (err_cnt4)
`endif
    );

    dmux_stream #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_sel    (in_sel3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3)
`ifdef DMUX_ERR_EN
        ,
        .err       (err3),
        .err_cnt   (err_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [1:0] sel, input logic [15:0] data);
        in_valid4 = 1'b1;
        in_sel4   = sel;
        in_data4  = data;
        #1;
    endtask

    initial begin
        // Reset state
        in_valid4 = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid4), 64'h0);
        chk("rst_data", out_data4, 64'h0);
        chk("rst_ready", 64'(in_ready4), 64'h0);
        in_valid4 = 1'b0;
        step();
        reset = 1'b0;

        // Streaming to all four channels with every sink ready
        out_ready4 = 4'hF;
        send4(2'd0, 16'h1111);
        chk("a_rdy0", 64'(in_ready4), 64'h1);
        step();
        chk("a_v0", 64'(out_valid4), 64'h1);
        chk("a_d0", 64'(out_data4[15:0]), 64'h1111);
        send4(2'd1, 16'h2222);
        chk("a_rdy1", 64'(in_ready4), 64'h1);
        step();
        chk("a_v1", 64'(out_valid4), 64'h2);
        chk("a_d1", 64'(out_data4[31:16]), 64'h2222);
        send4(2'd2, 16'h3333);
        chk("a_rdy2", 64'(in_ready4), 64'h1);
        step();
        chk("a_v2", 64'(out_valid4), 64'h4);
        chk("a_d2", 64'(out_data4[47:32]), 64'h3333);
        send4(2'd3, 16'h4444);
        chk("a_rdy3", 64'(in_ready4), 64'h1);
        step();
        chk("a_v3", 64'(out_valid4), 64'h8);
        chk("a_d3", 64'(out_data4[63:48]), 64'h4444);
        in_valid4 = 1'b0;
        step();
        chk("a_drain", 64'(out_valid4), 64'h0);
        chk("a_keep", out_data4, 64'h4444_3333_2222_1111);

        // Backpressure on channel 2, then drain and reload on the same edge
        out_ready4 = 4'b1011;
        send4(2'd2, 16'hAAAA);
        chk("b_rdy_first", 64'(in_ready4), 64'h1);
        step();
        chk("b_v_first", 64'(out_valid4), 64'h4);
        send4(2'd2, 16'hBBBB);
        chk("b_rdy_stall", 64'(in_ready4), 64'h0);
        step();
        chk("b_hold_v", 64'(out_valid4), 64'h4);
        chk("b_hold_d", 64'(out_data4[47:32]), 64'hAAAA);
        out_ready4 = 4'hF;
        #1;
        chk("b_rdy_release", 64'(in_ready4), 64'h1);
        step();
        chk("b_swap_v", 64'(out_valid4), 64'h4);
        chk("b_swap_d", 64'(out_data4[47:32]), 64'hBBBB);
        in_valid4 = 1'b0;
        step();
        chk("b_empty", 64'(out_valid4), 64'h0);

        // Channel 1 stalled full; channels 0 and 3 keep flowing
        out_ready4 = 4'b1101;
        send4(2'd1, 16'hCCCC);
        step();
        chk("c_v_full", 64'(out_valid4), 64'h2);
        send4(2'd0, 16'h0101);
        chk("c_rdy0", 64'(in_ready4), 64'h1);
        step();
        chk("c_v_a", 64'(out_valid4), 64'h3);
        chk("c_d0", 64'(out_data4[15:0]), 64'h0101);
        chk("c_d1_a", 64'(out_data4[31:16]), 64'hCCCC);
        send4(2'd3, 16'h0303);
        chk("c_rdy3", 64'(in_ready4), 64'h1);
        step();
        chk("c_v_b", 64'(out_valid4), 64'hA);
        chk("c_d3", 64'(out_data4[63:48]), 64'h0303);
        chk("c_d1_b", 64'(out_data4[31:16]), 64'hCCCC);
        send4(2'd1, 16'hDDDD);
        chk("c_rdy1_stall", 64'(in_ready4), 64'h0);
        in_valid4 = 1'b0;
        step();
        chk("c_v_c", 64'(out_valid4), 64'h2);
        out_ready4 = 4'hF;
        step();
        chk("c_empty", 64'(out_valid4), 64'h0);

        // Asynchronous reset with channels 0 and 2 full and a beat pending
        out_ready4 = 4'b1010;
        send4(2'd0, 16'h0A0A);
        step();
        send4(2'd2, 16'h0C0C);
        step();
        chk("d_full", 64'(out_valid4), 64'h5);
        send4(2'd0, 16'h0F0F);
        #1;
        reset = 1'b1;
        #1;
        chk("d_async_v", 64'(out_valid4), 64'h0);
        chk("d_async_d", out_data4, 64'h0);
        chk("d_async_rdy", 64'(in_ready4), 64'h0);
        step();
        chk("d_hold_v", 64'(out_valid4), 64'h0);
        chk("d_hold_rdy", 64'(in_ready4), 64'h0);
        reset = 1'b0;
        out_ready4 = 4'hF;
        send4(2'd0, 16'h0E0E);
        chk("d_rdy_after", 64'(in_ready4), 64'h1);
        step();
        chk("d_first_v", 64'(out_valid4), 64'h1);
        chk("d_first_d", 64'(out_data4[15:0]), 64'h0E0E);
        in_valid4 = 1'b0;

        // N=3: out-of-range select is accepted and discarded
        out_ready3 = 3'b000;
        in_valid3  = 1'b1;
        in_sel3    = 2'd1;
        in_data3   = 16'h7777;
        step();
        chk("e_v_ch1", 64'(out_valid3), 64'h2);
        in_sel3  = 2'd3;
        in_data3 = 16'h5555;
        #1;
        chk("e_rdy_oor", 64'(in_ready3), 64'h1);
        step();
        chk("e_v_oor", 64'(out_valid3), 64'h2);
        chk("e_d_oor", out_data3, 64'h0000_7777_0000);
`ifdef DMUX_ERR_EN
        chk("e_err", 64'(err3), 64'h1);
        chk("e_cnt1", 64'(err_cnt3), 64'h1);
        in_valid3 = 1'b0;
        step();
        chk("e_err_pulse", 64'(err3), 64'h0);
        in_valid3 = 1'b1;
        repeat (300) step();
        in_valid3 = 1'b0;
        step();
        chk("e_cnt_sat", 64'(err_cnt3), 64'hFF);
        chk("e_err_idle", 64'(err3), 64'h0);
`endif
        in_valid3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
DMUX_STREAM -- requirements
Module: dmux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter N, default 4: number of output channels, legal range 2..16.
REQ-003 SHALL have parameter SELW, default 2: select width, sized by the instantiator so that 2**SELW >= N.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1: input beat present.
REQ-007 SHALL have port in_ready  output  1: input beat accepted this cycle when high together with in_valid.
REQ-008 SHALL have port in_sel  input  SELW: destination channel index.
REQ-009 SHALL have port in_data  input  WIDTH: input word.
REQ-010 SHALL have port out_valid  output  N: per-channel beat present.
REQ-011 SHALL have port out_ready  input  N: per-channel sink ready.
REQ-012 SHALL have port out_data  output  N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port err  output  1: only when DMUX_ERR_EN is defined (see Configuration).
REQ-014 SHALL have port err_cnt  output  8: only when DMUX_ERR_EN is defined (see Configuration).

Function
REQ-015 SHALL hold exactly one output register (valid bit plus WIDTH data) per channel.
REQ-016 SHALL define acceptance as in_valid && in_ready on a clock edge.
REQ-017 SHALL, for in_sel < N, drive in_ready = !out_valid[in_sel] || out_ready[in_sel]; combinational, no other channel participates.
REQ-018 SHALL, on acceptance with in_sel < N, load in_data into channel in_sel and set out_valid[in_sel] on the same edge; latency 1 cycle.
REQ-019 SHALL clear out_valid[k] on an edge where out_valid[k] && out_ready[k] && no new beat is loaded into k.
REQ-020 SHALL, on simultaneous drain and load of channel k, keep out_valid[k]=1 with the new word; full throughput of 1 beat/cycle per channel.
REQ-021 SHALL keep out_data of channel k stable while out_valid[k] && !out_ready[k].
REQ-022 SHALL leave non-selected channels unaffected by input activity.
REQ-023 SHALL preserve order per channel; no ordering across channels is guaranteed.
REQ-024 SHALL, for in_sel >= N (reachable only when N < 2**SELW), drive in_ready=1 and discard the beat; no channel changes.
REQ-025 SHALL make out_data of an invalid channel don't-care, but deterministic (last loaded word, or 0 after reset).

Reset
REQ-026 SHALL, while reset is high, force out_valid=0, out_data=0 and in_ready=0 immediately (asynchronous).
REQ-027 SHALL discard beats pending at reset assertion mid-operation; no partial transfer completes.
REQ-028 SHALL permit the first acceptance on the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL compile out-of-range error reporting in only when macro DMUX_ERR_EN is defined.
REQ-030 SHALL, with DMUX_ERR_EN defined, pulse err high for exactly the one cycle following a discarded out-of-range beat (registered).
REQ-031 SHALL, with DMUX_ERR_EN defined, increment err_cnt by 1 per discarded beat, saturating at 255; err and err_cnt reset to 0.
REQ-032 SHALL, without DMUX_ERR_EN, omit the err and err_cnt ports; out-of-range beats are dropped silently per REQ-024.

Verification
REQ-033 SHALL cover: N=4, all out_ready=1, send 0x1111/0x2222/0x3333/0x4444 with sel 0..3 on consecutive cycles -> each out_valid[k] high one cycle after its beat, data matches, in_ready constantly 1.
REQ-034 SHALL cover: out_ready[2]=0, send two beats to sel=2 -> first held at 0xAAAA, in_ready=0 for second; raise out_ready[2] -> 0xAAAA drains and second beat 0xBBBB loads on the same edge.
REQ-035 SHALL cover: channel 1 stalled full while beats to sel=0 and sel=3 flow -> in_ready=1 for those, channel 1 data unchanged.
REQ-036 SHALL cover: N=3, SELW=2, sel=3 beat 0x5555 -> in_ready=1, no out_valid change; with DMUX_ERR_EN, err pulses 1 cycle and err_cnt=1; 300 such beats -> err_cnt=255.
REQ-037 SHALL cover: reset asserted mid-cycle with channels 0 and 2 full -> out_valid=0 and out_data=0 immediately without a clk edge, in_ready=0 until deassert.
